// File: rtl/ysyx_25060170_lsu_wb_if.sv
// Request/response memory bus between the LSU/writeback unit and the data memory.
interface ysyx_25060170_lsu_wb_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25060170_lsu_wb.sv
// Multi-cycle load/store + writeback unit: one instruction at a time, memory access over
// a valid/ready bus, load alignment/extension, single-cycle register-file write.
module ysyx_25060170_lsu_wb #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic [31:0] in_sdata,
  ysyx_25060170_lsu_wb_if.master mem,
  output logic        GPR_we,
  output logic [4:0]  GPR_writer,
  output logic [31:0] GPR_wd,
  output logic        done,
  output logic        err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LOAD  = 2'b01;
  localparam logic [1:0] K_STORE = 2'b10;
  localparam logic [1:0] K_NOP   = 2'b11;

  logic [2:0]      state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            err_flag_q, err_flag_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic            in_ready_q, in_ready_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_wen_q, mem_wen_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wmask_q, mem_wmask_d;
  logic            gpr_we_q, gpr_we_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            legal_c;
  logic [3:0]      lane_wmask_c;
  logic [XLEN-1:0] lane_wdata_c;
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;
  logic [XLEN-1:0] ld_data_c;
  logic [TO_W-1:0] cnt_inc_c;

  // Legality of an incoming memory access: funct3 encoding plus natural alignment.
  always_comb begin
    legal_c = 1'b0;
    if (in_kind == K_LOAD) begin
      legal_c = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end else if (in_kind == K_STORE) begin
      legal_c = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end
    if (in_funct3[1:0] == 2'b01 && in_result[0]) begin
      legal_c = 1'b0;
    end
    if (in_funct3[1:0] == 2'b10 && in_result[1:0] != 2'b00) begin
      legal_c = 1'b0;
    end
  end

  // Store byte lanes: data replicated across the word, strobes pick the addressed lanes.
  always_comb begin
    lane_wmask_c = 4'b0000;
    lane_wdata_c = in_sdata;
    if (in_kind == K_STORE) begin
      case (in_funct3)
        3'b000: begin
          lane_wmask_c = 4'(4'b0001 << in_result[1:0]);
          lane_wdata_c = {4{in_sdata[7:0]}};
        end
        3'b001: begin
          lane_wmask_c = 4'(4'b0011 << in_result[1:0]);
          lane_wdata_c = {2{in_sdata[15:0]}};
        end
        default: begin
          lane_wmask_c = 4'b1111;
          lane_wdata_c = in_sdata;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched byte offset.
  always_comb begin
    ld_byte_c = 8'(mem.mem_rdata >> {addr_q[1:0], 3'b000});
    ld_half_c = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_data_c = {24'd0, ld_byte_c};
      3'b101:  ld_data_c = {16'd0, ld_half_c};
      default: ld_data_c = mem.mem_rdata;
    endcase
  end

  assign cnt_inc_c = TO_W'(cnt_q + TO_W'(1));

  // Next-state, operand latching and registered output decode.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    err_flag_d  = err_flag_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          kind_d      = in_kind;
          funct3_d    = in_funct3;
          rd_d        = in_rd;
          addr_d      = in_result;
          wd_d        = in_result;
          err_flag_d  = 1'b0;
          cnt_d       = '0;
          mem_addr_d  = {in_result[31:2], 2'b00};
          mem_wen_d   = (in_kind == K_STORE);
          mem_wdata_d = lane_wdata_c;
          mem_wmask_d = lane_wmask_c;
          case (in_kind)
            K_ALU:   state_d = S_WB;
            K_NOP:   state_d = S_FIN;
            default: begin
              if (legal_c) begin
                state_d = S_REQ;
              end else begin
                state_d    = S_FIN;
                err_flag_d = 1'b1;
              end
            end
          endcase
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          if (kind_q == K_LOAD) begin
            wd_d    = ld_data_c;
            state_d = S_WB;
          end else begin
            state_d = S_FIN;
          end
        end else if (TIMEOUT != 0 && cnt_inc_c == TO_W'(TIMEOUT)) begin
          state_d    = S_FIN;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_WB:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    req_valid_d = (state_d == S_REQ);
    gpr_we_d    = (state_d == S_WB) && (rd_d != '0);
    done_d      = (state_d == S_FIN);
    err_d       = (state_d == S_FIN) && err_flag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_NOP;
      funct3_q    <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      err_flag_q  <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      req_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      gpr_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      err_flag_q  <= err_flag_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      req_valid_q <= req_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      gpr_we_q    <= gpr_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_addr      = mem_addr_q;
  assign mem.mem_wen       = mem_wen_q;
  assign mem.mem_wdata     = mem_wdata_q;
  assign mem.mem_wmask     = mem_wmask_q;
  assign GPR_we            = gpr_we_q;
  assign GPR_writer        = rd_q;
  assign GPR_wd            = wd_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu_wb.sv
// Directed bench for ysyx_25060170_lsu_wb with a hand-driven memory bus (TIMEOUT=4).
module tb_ysyx_25060170_lsu_wb;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TO_W    = 3;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LOAD  = 2'b01;
  localparam logic [1:0] K_STORE = 2'b10;
  localparam logic [1:0] K_NOP   = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_sdata;
  logic        GPR_we;
  logic [4:0]  GPR_writer;
  logic [31:0] GPR_wd;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int we_cnt      = 0;
  int req_cnt     = 0;

  ysyx_25060170_lsu_wb_if mem ();

  ysyx_25060170_lsu_wb #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_funct3  (in_funct3),
    .in_rd      (in_rd),
    .in_result  (in_result),
    .in_sdata   (in_sdata),
    .mem        (mem),
    .GPR_we     (GPR_we),
    .GPR_writer (GPR_writer),
    .GPR_wd     (GPR_wd),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (GPR_we) we_cnt++;
    if (mem.mem_req_valid) req_cnt++;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd);
    in_kind   = kind;
    in_funct3 = f3;
    in_rd     = rd;
    in_result = res;
    in_sdata  = sd;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Load with a given request stall and response delay; checks the writeback then done.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] rdata, input int stall,
                          input int wait_n, input logic [31:0] exp_wd);
    int we0;
    mem.mem_req_ready = 1'b0;
    issue(K_LOAD, f3, rd, addr, 32'h0);
    check_eq({tag, "_req_valid"}, 32'(mem.mem_req_valid), 32'd1);
    check_eq({tag, "_addr"}, mem.mem_addr, {addr[31:2], 2'b00});
    check_eq({tag, "_wen"}, 32'(mem.mem_wen), 32'd0);
    for (int i = 0; i < stall; i++) tick();
    check_eq({tag, "_req_held"}, 32'(mem.mem_req_valid), 32'd1);
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    for (int i = 0; i < wait_n; i++) tick();
    mem.mem_rdata      = rdata;
    mem.mem_resp_valid = 1'b1;
    we0 = we_cnt;
    tick();
    mem.mem_resp_valid = 1'b0;
    check_eq({tag, "_we"}, 32'(GPR_we), (rd != 5'd0) ? 32'd1 : 32'd0);
    check_eq({tag, "_writer"}, 32'(GPR_writer), 32'(rd));
    check_eq({tag, "_wd"}, GPR_wd, exp_wd);
    tick();
    check_eq({tag, "_done"}, {30'd0, done, err}, 32'd2);
    check_eq({tag, "_we_once"}, 32'(we_cnt - we0), (rd != 5'd0) ? 32'd1 : 32'd0);
    tick();
  endtask

  // Faulting access: done and err in the cycle after accept, no request, no write.
  task automatic run_fault(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                           input logic [31:0] addr);
    int we0;
    int rq0;
    we0 = we_cnt;
    rq0 = req_cnt;
    issue(kind, f3, 5'd4, addr, 32'h1234_5678);
    check_eq({tag, "_done_err"}, {30'd0, done, err}, 32'd3);
    tick();
    check_eq({tag, "_no_side"}, 32'((we_cnt - we0) + (req_cnt - rq0)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    int we0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_kind = K_NOP;
    in_funct3 = 3'd0;
    in_rd = 5'd0;
    in_result = 32'd0;
    in_sdata = 32'd0;
    mem.mem_req_ready = 1'b0;
    mem.mem_resp_valid = 1'b0;
    mem.mem_rdata = 32'd0;

    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_outs", {26'd0, done, err, GPR_we, mem.mem_req_valid, mem.mem_wen, 1'b0}, 32'd0);
    check_eq("rst_bus", mem.mem_addr | mem.mem_wdata | 32'(mem.mem_wmask), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    // ALU writeback
    issue(K_ALU, 3'd0, 5'd5, 32'h1234_5678, 32'h0);
    check_eq("alu_we", 32'(GPR_we), 32'd1);
    check_eq("alu_writer", 32'(GPR_writer), 32'd5);
    check_eq("alu_wd", GPR_wd, 32'h1234_5678);
    check_eq("alu_busy", 32'(in_ready), 32'd0);
    tick();
    check_eq("alu_done", {30'd0, done, err}, 32'd2);
    check_eq("alu_we_drop", 32'(GPR_we), 32'd0);
    tick();
    check_eq("alu_ready", 32'(in_ready), 32'd1);

    // No-op
    we0 = we_cnt;
    issue(K_NOP, 3'd0, 5'd6, 32'hFFFF_FFFF, 32'h0);
    check_eq("nop_done", {30'd0, done, err}, 32'd2);
    tick();
    check_eq("nop_no_we", 32'(we_cnt - we0), 32'd0);

    // Loads
    run_load("lb",  3'b000, 5'd7,  32'h8000_0003, 32'h80FF_0000, 2, 2, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 5'd7,  32'h8000_0003, 32'h80FF_0000, 2, 2, 32'h0000_0080);
    run_load("lh",  3'b001, 5'd8,  32'h8000_0002, 32'h9ABC_1234, 0, 0, 32'hFFFF_9ABC);
    run_load("lhu", 3'b101, 5'd8,  32'h8000_0000, 32'h1234_F00D, 1, 0, 32'h0000_F00D);
    run_load("lb1", 3'b000, 5'd9,  32'h8000_0001, 32'h1234_7F00, 0, 1, 32'h0000_007F);
    run_load("lw0", 3'b010, 5'd0,  32'h8000_0020, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);

    // SH with one-cycle stall
    we0 = we_cnt;
    mem.mem_req_ready = 1'b0;
    issue(K_STORE, 3'b001, 5'd3, 32'h8000_0002, 32'hAAAA_BEEF);
    check_eq("sh_addr", mem.mem_addr, 32'h8000_0000);
    check_eq("sh_wen", 32'(mem.mem_wen), 32'd1);
    check_eq("sh_wmask", 32'(mem.mem_wmask), 32'hC);
    check_eq("sh_wdata", mem.mem_wdata, 32'hBEEF_BEEF);
    check_eq("sh_busy", 32'(in_ready), 32'd0);
    tick();
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    check_eq("sh_req_drop", 32'(mem.mem_req_valid), 32'd0);
    mem.mem_resp_valid = 1'b1;
    tick();
    mem.mem_resp_valid = 1'b0;
    check_eq("sh_done", {30'd0, done, err}, 32'd2);
    tick();
    check_eq("sh_no_we", 32'(we_cnt - we0), 32'd0);

    // SB and SW lane checks
    issue(K_STORE, 3'b000, 5'd3, 32'h0000_0101, 32'h1234_56A5);
    check_eq("sb_wmask", 32'(mem.mem_wmask), 32'h2);
    check_eq("sb_wdata", mem.mem_wdata, 32'hA5A5_A5A5);
    check_eq("sb_addr", mem.mem_addr, 32'h0000_0100);
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    mem.mem_resp_valid = 1'b1;
    tick();
    mem.mem_resp_valid = 1'b0;
    check_eq("sb_done", {30'd0, done, err}, 32'd2);
    tick();
    issue(K_STORE, 3'b010, 5'd3, 32'h0000_0200, 32'hCAFE_F00D);
    check_eq("sw_wmask", 32'(mem.mem_wmask), 32'hF);
    check_eq("sw_wdata", mem.mem_wdata, 32'hCAFE_F00D);
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    mem.mem_resp_valid = 1'b1;
    tick();
    mem.mem_resp_valid = 1'b0;
    check_eq("sw_done", {30'd0, done, err}, 32'd2);
    tick();

    // Faults
    run_fault("lw_mis",  K_LOAD,  3'b010, 32'h8000_0001);
    run_fault("ld_f011", K_LOAD,  3'b011, 32'h8000_0000);
    run_fault("sh_mis",  K_STORE, 3'b001, 32'h8000_0003);
    run_fault("st_f100", K_STORE, 3'b100, 32'h8000_0000);

    // Timeout: 4 WAIT cycles without response, then a stray response
    we0 = we_cnt;
    mem.mem_req_ready = 1'b1;
    issue(K_LOAD, 3'b010, 5'd9, 32'h8000_0010, 32'h0);
    tick();
    mem.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("to_not_yet", 32'(done), 32'd0);
    tick();
    check_eq("to_done_err", {30'd0, done, err}, 32'd3);
    mem.mem_rdata = 32'h5555_5555;
    mem.mem_resp_valid = 1'b1;
    tick();
    check_eq("to_ready", 32'(in_ready), 32'd1);
    tick();
    mem.mem_resp_valid = 1'b0;
    check_eq("to_stray", {30'd0, done, GPR_we}, 32'd0);
    check_eq("to_no_we", 32'(we_cnt - we0), 32'd0);

    // Reset during WAIT, then a late response
    we0 = we_cnt;
    mem.mem_req_ready = 1'b1;
    issue(K_LOAD, 3'b010, 5'd10, 32'h8000_0030, 32'h0);
    tick();
    mem.mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_outs", {29'd0, done, GPR_we, mem.mem_req_valid}, 32'd0);
    mem.mem_rdata = 32'h7777_7777;
    mem.mem_resp_valid = 1'b1;
    tick();
    check_eq("mrst_ready", 32'(in_ready), 32'd1);
    tick();
    mem.mem_resp_valid = 1'b0;
    check_eq("mrst_late", {30'd0, done, GPR_we}, 32'd0);
    check_eq("mrst_no_we", 32'(we_cnt - we0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_lsu_wb.md
Name: ysyx_25060170_lsu_wb

Overview:
- Multi-cycle load/store and writeback unit sitting directly upstream of the general-purpose register file.
- Accepts one decoded instruction result at a time from the execute stage.
- Performs the memory access, if any, over a valid/ready request and response bus.
- Aligns and extends load data, then drives the register-file write port (GPR_we, GPR_writer, GPR_wd) for exactly one cycle per writing instruction.

Parameters:
- TIMEOUT, 256: cycles allowed in WAIT before an error is flagged; 0 disables the watchdog.
- TO_W, 9: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  unit idle and able to accept.
- in_kind  in  2  00 ALU writeback, 01 load, 10 store, 11 no-op (no write).
- in_funct3  in  3  RISC-V funct3 for load/store.
- in_rd  in  5  destination register.
- in_result  in  32  ALU result, or byte address for load/store.
- in_sdata  in  32  store data (rs2).
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wen  out  1  1 = write.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte strobes.
- mem_resp_valid  in  1  read data or write acknowledge.
- mem_rdata  in  32  read word.
- GPR_we  out  1  register-file write enable.
- GPR_writer  out  5  write address.
- GPR_wd  out  32  write data.
- done  out  1  one-cycle pulse when the instruction retires.
- err  out  1  one-cycle pulse coincident with done on a faulting instruction.

Behaviour:
- Reset: state IDLE. in_ready=1 only after reset deasserts. All other outputs 0, counter 0.
- States: IDLE, REQ, WAIT, WB, FIN. All outputs are registered or decoded from state and latched operands.
- IDLE: in_ready=1. On in_valid, latch all in_* fields. Next state depends on the instruction:
  - ALU → WB.
  - No-op → FIN.
  - Load/store with illegal funct3 or misalignment → FIN with the error flag set.
  - Legal load/store → REQ.
- Legal funct3:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- Misalignment: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ: mem_req_valid=1. Address, wen, wdata and wmask stay stable until mem_req_ready. On handshake, go to WAIT and clear the counter. mem_req_valid must not drop before the handshake.
- Store lanes:
  - SB: wmask = 0001<<addr[1:0]; wdata = {4{sdata[7:0]}}.
  - SH: wmask = 0011<<addr[1:0]; wdata = {2{sdata[15:0]}}.
  - SW: wmask = 1111; wdata = sdata.
  - Loads: wmask = 0000.
- WAIT: mem_resp_valid is sampled only in this state; a response in REQ or IDLE is ignored.
  - On response: load → WB with extracted data registered; store → FIN.
  - No response: the counter increments. When it reaches TIMEOUT (TIMEOUT≠0) → FIN with error; a later stray response is ignored.
- Load extract: byte/halfword selected by addr[1:0]; sign-extended for LB/LH, zero-extended for LBU/LHU.
- WB: GPR_we=1 for exactly this cycle, with GPR_writer=rd and GPR_wd = ALU result or load data.
  - If rd=0, GPR_we=0 but GPR_writer/GPR_wd are still driven.
  - Next state FIN.
- FIN: done=1, err=error flag, then → IDLE.
- Latency from acceptance to done:
  - ALU: 2 cycles.
  - No-op or fault: 1 cycle.
  - Load/store: 2 + request stall + response wait (+1 for a load's WB).
- GPR_we is never asserted for stores, no-ops or faults.
- in_valid while not IDLE is ignored; in_ready=0.
- Reset mid-operation: immediate return to IDLE, no GPR write, no done. Any outstanding memory response is discarded.

Test Plan:
- ALU, rd=5, result 0x1234_5678 → GPR_we high one cycle 1 after accept with writer=5, wd=0x12345678; done next cycle, err=0.
- LB at addr 0x8000_0003, mem_rdata=0x80FF_0000, req_ready 2 cycles late, resp 3 cycles after → mem_addr=0x8000_0000, wen=0; GPR_wd=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH at addr 0x8000_0002, sdata=0xAAAA_BEEF → wmask=1100, wdata=0xBEEF_BEEF, wen=1; done after ack, GPR_we never high.
- LW at addr 0x8000_0001 → no mem_req_valid, done and err together in the cycle after accept. funct3=011 load → same.
- Load with TIMEOUT=4 and no response → err+done after 4 WAIT cycles; a response injected afterwards is ignored and in_ready=1.
- Load with rd=0 → GPR_we stays 0, done=1. rst asserted during WAIT → next cycle in_ready=1, no done; a late resp is ignored.
